// File: rtl/t9990_blit_rect_seq_pkg.sv
// Shared definitions for the T9990 blitter rectangle walker: default cursor widths
// and the sequencer state encoding.
package T9990_REG;

  localparam int XW_DEF = 11;
  localparam int YW_DEF = 12;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_CALC = 3'd2,
    ST_REQ  = 3'd3,
    ST_STEP = 3'd4,
    ST_FIN  = 3'd5
  } state_t;

endpackage

// File: rtl/t9990_blit_step_ctr.sv
// Loadable pixel/line down-counter. One extra bit so a zero load means 2^W;
// last_o flags the final pixel/line (count == 1).
module t9990_blit_step_ctr #(
  parameter int W = 11
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         last_o
);

  localparam logic [W:0] ONE = {{W{1'b0}}, 1'b1};

  logic [W:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = {~|load_val_i, load_val_i};
    else if (dec_i)
      cnt_d = cnt_q - ONE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign last_o = (cnt_q == ONE);

endmodule

// File: rtl/t9990_blit_rect_seq.sv
// T9990 blitter rectangle walker: steps an (X,Y) cursor over an NX x NY area and
// handshakes one VRAM access per pixel with the arbiter.
module t9990_blit_rect_seq
  import T9990_REG::*;
#(
  parameter int XW = XW_DEF,
  parameter int YW = YW_DEF
) (
  input  logic          CLK,
  input  logic          RESET_n,
  input  logic          START,
  input  logic          STOP,
  input  logic [XW-1:0] DX,
  input  logic [YW-1:0] DY,
  input  logic [XW-1:0] NX,
  input  logic [YW-1:0] NY,
  input  logic          DIX,
  input  logic          DIY,
  output logic [XW-1:0] X,
  output logic [YW-1:0] Y,
  output logic          REQ,
  input  logic          ACK,
  output logic          BUSY,
  output logic          DONE
);

  localparam logic [XW-1:0] X_ONE = {{(XW-1){1'b0}}, 1'b1};
  localparam logic [YW-1:0] Y_ONE = {{(YW-1){1'b0}}, 1'b1};

  state_t        state_q, state_d;
  logic [XW-1:0] x_q, x_d, dx_q, dx_d, nx_q, nx_d;
  logic [YW-1:0] y_q, y_d;
  logic          dix_q, dix_d, diy_q, diy_d;
  logic          req_q, req_d, busy_q, busy_d;
  logic          cx_load, cx_dec, cx_last;
  logic          cy_load, cy_dec, cy_last;
  logic [XW-1:0] cx_ldval;

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    dx_d     = dx_q;
    nx_d     = nx_q;
    dix_d    = dix_q;
    diy_d    = diy_q;
    req_d    = req_q;
    busy_d   = busy_q;
    cx_load  = 1'b0;
    cx_dec   = 1'b0;
    cx_ldval = nx_q;
    cy_load  = 1'b0;
    cy_dec   = 1'b0;
    case (state_q)
      ST_IDLE: if (START && !STOP) begin
        x_d      = DX;
        y_d      = DY;
        dx_d     = DX;
        nx_d     = NX;
        dix_d    = DIX;
        diy_d    = DIY;
        cx_load  = 1'b1;
        cx_ldval = NX;
        cy_load  = 1'b1;
        busy_d   = 1'b1;
        state_d  = ST_LOAD;
      end
      ST_LOAD: state_d = ST_CALC;
      ST_CALC: begin
        req_d   = 1'b1;
        state_d = ST_REQ;
      end
      ST_REQ: if (ACK) begin
        req_d   = 1'b0;
        state_d = ST_STEP;
      end
      ST_STEP: begin
        if (!cx_last) begin
          x_d     = dix_q ? (x_q - X_ONE) : (x_q + X_ONE);
          cx_dec  = 1'b1;
          state_d = ST_CALC;
        end else if (!cy_last) begin
          // End of line: rewind X to the latched start and advance one line.
          x_d     = dx_q;
          cx_load = 1'b1;
          y_d     = diy_q ? (y_q - Y_ONE) : (y_q + Y_ONE);
          cy_dec  = 1'b1;
          state_d = ST_CALC;
        end else begin
          state_d = ST_FIN;
        end
      end
      ST_FIN: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Abort overrides everything; an access acked in the same cycle is already taken.
    if (STOP && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
      req_d   = 1'b0;
      busy_d  = 1'b0;
      x_d     = x_q;
      y_d     = y_q;
      cx_load = 1'b0;
      cx_dec  = 1'b0;
      cy_dec  = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      dx_q    <= '0;
      nx_q    <= '0;
      dix_q   <= 1'b0;
      diy_q   <= 1'b0;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      dx_q    <= dx_d;
      nx_q    <= nx_d;
      dix_q   <= dix_d;
      diy_q   <= diy_d;
      req_q   <= req_d;
      busy_q  <= busy_d;
    end
  end

  t9990_blit_step_ctr #(.W(XW)) u_cx (
    .clk_i      (CLK),
    .rst_ni     (RESET_n),
    .load_i     (cx_load),
    .load_val_i (cx_ldval),
    .dec_i      (cx_dec),
    .last_o     (cx_last)
  );

  t9990_blit_step_ctr #(.W(YW)) u_cy (
    .clk_i      (CLK),
    .rst_ni     (RESET_n),
    .load_i     (cy_load),
    .load_val_i (NY),
    .dec_i      (cy_dec),
    .last_o     (cy_last)
  );

  assign X    = x_q;
  assign Y    = y_q;
  assign REQ  = req_q;
  assign BUSY = busy_q;
  assign DONE = (state_q == ST_FIN);

endmodule

// File: tb/tb_t9990_blit_rect_seq.sv
// Scoreboard bench for the T9990 rectangle walker: expected pixel coordinates and
// DONE pulses are queued by the stimulus and consumed by a negedge monitor.
module tb_t9990_blit_rect_seq;

  logic        CLK = 1'b0;
  logic        RESET_n = 1'b1;
  logic        START = 1'b0, STOP = 1'b0, ACK = 1'b1;
  logic [10:0] DX = '0, NX = '0, X;
  logic [11:0] DY = '0, NY = '0, Y;
  logic        DIX = 1'b0, DIY = 1'b0;
  logic        REQ, BUSY, DONE;

  typedef struct {bit is_done; int x; int y;} exp_t;
  exp_t q[$];
  int total = 0, passed = 0;

  t9990_blit_rect_seq dut (
    .CLK(CLK), .RESET_n(RESET_n), .START(START), .STOP(STOP),
    .DX(DX), .DY(DY), .NX(NX), .NY(NY), .DIX(DIX), .DIY(DIY),
    .X(X), .Y(Y), .REQ(REQ), .ACK(ACK), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic push_px(input int x, input int y);
    exp_t e;
    e.is_done = 1'b0; e.x = x; e.y = y;
    q.push_back(e);
  endtask

  task automatic push_done();
    exp_t e;
    e.is_done = 1'b1; e.x = 0; e.y = 0;
    q.push_back(e);
  endtask

  // Monitor: X/Y must match the queued pixel on every REQ cycle; pop on handshake.
  always @(negedge CLK) begin
    if (RESET_n) begin
      if (REQ) begin
        check("req_expected", int'(q.size() > 0 && !q[0].is_done), 1);
        if (q.size() > 0 && !q[0].is_done) begin
          check("req_x", int'(X), q[0].x);
          check("req_y", int'(Y), q[0].y);
          if (ACK) void'(q.pop_front());
        end
      end
      if (DONE) begin
        check("done_expected", int'(q.size() > 0 && q[0].is_done), 1);
        if (q.size() > 0 && q[0].is_done) void'(q.pop_front());
      end
    end
  end

  task automatic start_pulse(input int dx, input int dy, input int nx, input int ny,
                             input bit dix, input bit diy);
    @(posedge CLK); #1;
    DX = 11'(dx); DY = 12'(dy); NX = 11'(nx); NY = 12'(ny);
    DIX = dix; DIY = diy; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
  endtask

  task automatic wait_done(output int busy_n, output int req_lat);
    int n = 0;
    bit seen = 0;
    busy_n = 0; req_lat = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge CLK);
      n++;
      if (BUSY) busy_n++;
      if (REQ && req_lat == 0) req_lat = n;
      if (DONE) seen = 1;
      if (seen && !BUSY) break;
    end
    check("done_seen", int'(seen), 1);
  endtask

  initial begin
    int bn, lat, rc, cnt;
    bit got_done;

    #2 RESET_n = 1'b0;
    #1;
    check("rst_x", int'(X), 0);
    check("rst_y", int'(Y), 0);
    check("rst_req", int'(REQ), 0);
    check("rst_busy", int'(BUSY), 0);
    check("rst_done", int'(DONE), 0);
    #10 RESET_n = 1'b1;

    // 3x2 rectangle, ACK tied high
    ACK = 1'b1;
    push_px(10, 20); push_px(11, 20); push_px(12, 20);
    push_px(10, 21); push_px(11, 21); push_px(12, 21); push_done();
    start_pulse(10, 20, 3, 2, 0, 0);
    check("busy_after_start", int'(BUSY), 1);
    wait_done(bn, lat);
    check("t1_req_latency", lat, 3);
    check("t1_busy_cycles", bn, 20);
    check("t1_queue_empty", q.size(), 0);

    // decrementing X wraps 0 -> 2047
    push_px(1, 0); push_px(0, 0); push_px(2047, 0); push_done();
    start_pulse(1, 0, 3, 1, 1, 1);
    wait_done(bn, lat);
    check("t2_busy_cycles", bn, 11);

    // single pixel, ACK held off for 5 cycles of REQ (ACK while REQ=0 ignored)
    push_px(5, 7); push_done();
    ACK = 1'b1;
    start_pulse(5, 7, 1, 1, 0, 0);
    rc = 0; got_done = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge CLK); #1;
      if (REQ) rc++;
      if (DONE) got_done = 1;
      ACK = (rc == 0 || rc == 6);
      if (!BUSY) break;
    end
    ACK = 1'b1;
    check("t3_req_cycles", rc, 6);
    check("t3_done", int'(got_done), 1);

    // STOP together with ACK on the 2nd pixel of a 4-wide line
    push_px(100, 50); push_px(101, 50);
    start_pulse(100, 50, 4, 1, 0, 0);
    cnt = 0;
    for (int i = 0; i < 40 && cnt < 2; i++) begin
      @(posedge CLK); #1;
      if (REQ) cnt++;
    end
    STOP = 1'b1;
    @(posedge CLK); #1;
    STOP = 1'b0;
    check("t4_req_after_stop", int'(REQ), 0);
    check("t4_busy_after_stop", int'(BUSY), 0);
    check("t4_x_kept", int'(X), 101);
    repeat (5) @(posedge CLK);
    check("t4_queue_empty", q.size(), 0);
    push_px(0, 0); push_px(1, 0); push_done();
    start_pulse(0, 0, 2, 1, 0, 0);
    wait_done(bn, lat);

    // START and STOP together in IDLE: stay idle
    @(posedge CLK); #1;
    START = 1'b1; STOP = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0; STOP = 1'b0;
    check("t5_start_stop_idle", int'(BUSY), 0);
    @(posedge CLK); #1;
    check("t5_still_idle", int'(BUSY), 0);

    // START during BUSY with new DX/NX, left on the inputs: ignored
    push_px(30, 3); push_px(31, 3); push_px(30, 4); push_px(31, 4); push_done();
    start_pulse(30, 3, 2, 2, 0, 0);
    repeat (4) @(posedge CLK);
    #1;
    DX = 11'd500; DY = 12'd600; NX = 11'd7; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    wait_done(bn, lat);

    // asynchronous reset while in STEP
    push_px(40, 41);
    start_pulse(40, 41, 3, 1, 0, 0);
    for (int i = 0; i < 20; i++) begin
      @(posedge CLK); #1;
      if (REQ) break;
    end
    @(posedge CLK); #1;
    check("t6_x_before_rst", int'(X), 40);
    RESET_n = 1'b0;
    #1;
    check("t6_rst_x", int'(X), 0);
    check("t6_rst_y", int'(Y), 0);
    check("t6_rst_req", int'(REQ), 0);
    check("t6_rst_busy", int'(BUSY), 0);
    check("t6_rst_done", int'(DONE), 0);
    @(posedge CLK); #1;
    RESET_n = 1'b1;
    check("t6_queue_empty", q.size(), 0);
    push_px(7, 9); push_px(8, 9); push_done();
    start_pulse(7, 9, 2, 1, 0, 0);
    wait_done(bn, lat);
    check("t6_busy_cycles", bn, 8);

    repeat (3) @(posedge CLK);
    check("final_queue_empty", q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
